// File: rtl/picosoc_iomem_timer.sv
// PicoSoC iomem responder exposing a prescaled down-counter timer with
// auto-reload / one-shot modes, a sticky expiry flag and a level interrupt.
module picosoc_iomem_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter int          PRESCALE_WIDTH = 16,
    parameter int          COUNTER_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h01;
    localparam logic [5:0] OFF_LOAD     = 6'h02;
    localparam logic [5:0] OFF_COUNT    = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h04;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [2:0]                ctrl_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [COUNTER_WIDTH-1:0]  load_r;
    logic [COUNTER_WIDTH-1:0]  count_r;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_r;
    logic                      expired_r;
    logic                      ready_r;
    logic [31:0]               rdata_r;
    logic                      irq_r;

    logic [2:0]                ctrl_nxt_s;
    logic [PRESCALE_WIDTH-1:0] prescale_nxt_s;
    logic [COUNTER_WIDTH-1:0]  load_nxt_s;
    logic [COUNTER_WIDTH-1:0]  count_nxt_s;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_nxt_s;
    logic                      expired_nxt_s;
    logic [31:0]               rd_s;
    logic [31:0]               merged_s;
    logic                      hit_s;
    logic                      accept_s;
    logic                      wr_s;
    logic                      tick_s;
    logic                      expire_s;
    logic [5:0]                off_s;
    logic                      unused_s;

    assign hit_s    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign accept_s = hit_s && !ready_r;
    assign wr_s     = accept_s && (iomem_wstrb != 4'h0);
    assign off_s    = iomem_addr[7:2];
    assign tick_s   = ctrl_r[0] && (presc_cnt_r == prescale_r);
    assign expire_s = tick_s && (count_r == {COUNTER_WIDTH{1'b0}});
    assign merged_s = merge_bytes(rd_s, iomem_wdata, iomem_wstrb);
    assign unused_s = ^iomem_addr[1:0];

    // Read mux, timer advance and bus write merge; bus writes are applied last so they win.
    always_comb begin
        ctrl_nxt_s      = ctrl_r;
        prescale_nxt_s  = prescale_r;
        load_nxt_s      = load_r;
        count_nxt_s     = count_r;
        presc_cnt_nxt_s = presc_cnt_r;
        expired_nxt_s   = expired_r;
        rd_s            = 32'h0000_0000;

        case (off_s)
            OFF_CTRL:     rd_s[2:0]                = ctrl_r;
            OFF_PRESCALE: rd_s[PRESCALE_WIDTH-1:0] = prescale_r;
            OFF_LOAD:     rd_s[COUNTER_WIDTH-1:0]  = load_r;
            OFF_COUNT:    rd_s[COUNTER_WIDTH-1:0]  = count_r;
            OFF_STATUS:   rd_s[0]                  = expired_r;
            default:      rd_s                     = 32'h0000_0000;
        endcase

        if (!ctrl_r[0] || tick_s) begin
            presc_cnt_nxt_s = {PRESCALE_WIDTH{1'b0}};
        end else begin
            presc_cnt_nxt_s = presc_cnt_r + PRESCALE_WIDTH'(1);
        end

        if (tick_s && !expire_s) begin
            count_nxt_s = count_r - COUNTER_WIDTH'(1);
        end else if (expire_s) begin
            expired_nxt_s = 1'b1;
            if (ctrl_r[1]) begin
                count_nxt_s = load_r;
            end else begin
                ctrl_nxt_s[0] = 1'b0;
            end
        end else begin
            count_nxt_s = count_r;
        end

        if (wr_s) begin
            case (off_s)
                OFF_CTRL:     ctrl_nxt_s     = merged_s[2:0];
                OFF_PRESCALE: prescale_nxt_s = merged_s[PRESCALE_WIDTH-1:0];
                OFF_LOAD:     load_nxt_s     = merged_s[COUNTER_WIDTH-1:0];
                OFF_COUNT:    count_nxt_s    = merged_s[COUNTER_WIDTH-1:0];
                OFF_STATUS: begin
                    // a simultaneous expiry keeps the flag set
                    if (iomem_wstrb[0] && iomem_wdata[0] && !expire_s) begin
                        expired_nxt_s = 1'b0;
                    end else begin
                        expired_nxt_s = expired_nxt_s;
                    end
                end
                default:      ctrl_nxt_s     = ctrl_nxt_s;
            endcase
        end else begin
            ctrl_nxt_s = ctrl_nxt_s;
        end
    end

    // State and response registers; irq follows the next-state flags so it tracks STATUS exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r      <= 3'b000;
            prescale_r  <= {PRESCALE_WIDTH{1'b0}};
            load_r      <= {COUNTER_WIDTH{1'b0}};
            count_r     <= {COUNTER_WIDTH{1'b0}};
            presc_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            expired_r   <= 1'b0;
            ready_r     <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            irq_r       <= 1'b0;
        end else begin
            ctrl_r      <= ctrl_nxt_s;
            prescale_r  <= prescale_nxt_s;
            load_r      <= load_nxt_s;
            count_r     <= count_nxt_s;
            presc_cnt_r <= presc_cnt_nxt_s;
            expired_r   <= expired_nxt_s;
            ready_r     <= accept_s;
            rdata_r     <= accept_s ? rd_s : 32'h0000_0000;
            irq_r       <= expired_nxt_s && ctrl_nxt_s[2];
        end
    end

    assign iomem_ready = ready_r;
    assign iomem_rdata = rdata_r;
    assign irq         = irq_r;
endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Scoreboard bench for picosoc_iomem_timer: expected read data is queued when a
// request is driven and compared when the ready pulse appears.
module tb_picosoc_iomem_timer;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          en;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic prev_ready = 1'b0;

    picosoc_iomem_timer dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to predict where timer events land.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every ready pulse.
    always @(negedge clk) begin
        if (iomem_ready) begin
            check_val("ready_b2b", {31'h0, prev_ready}, 32'h0);
            if (sb.size() == 0) begin
                check_val("spurious_ready", 32'h1, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.en) check_val(mon_e.tag, iomem_rdata, mon_e.exp);
            end
        end
        prev_ready <= iomem_ready;
    end

    task automatic bus(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st,
                       input string tag, input logic [31:0] exp, input bit en);
        int waits;
        sb.push_back('{tag, exp, en});
        iomem_addr  = BASE + {24'h0, off};
        iomem_wdata = wd;
        iomem_wstrb = st;
        iomem_valid = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!iomem_ready && waits < 8);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        check_val({tag, "_latency"}, 32'(waits), 32'd1);
        if (!iomem_ready && sb.size() > 0) sb.delete(sb.size() - 1);
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        bus(off, 32'h0, 4'h0, tag, exp, 1'b1);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st);
        bus(off, wd, st, "wr", 32'h0, 1'b0);
    endtask

    initial begin
        int e0;
        int k;
        int nready;
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check_val("rst_rdata", iomem_rdata, 32'h0);
        check_val("rst_irq", {31'h0, irq}, 32'h0);
        rd(8'h0C, 32'h0, "rst_count");
        rd(8'h00, 32'h0, "rst_ctrl");

        // Requests outside the window never get a response.
        iomem_addr  = 32'h0400_0000;
        iomem_valid = 1'b1;
        nready = 0;
        repeat (10) begin
            @(negedge clk);
            if (iomem_ready) nready++;
        end
        iomem_valid = 1'b0;
        check_val("nohit_ready", 32'(nready), 32'h0);
        @(negedge clk);

        // Auto-reload at PRESCALE=0: count after enable edge k is 3-(k%4).
        wr(8'h0C, 32'h3, 4'hF);
        wr(8'h04, 32'h0, 4'hF);
        wr(8'h08, 32'h3, 4'hF);
        e0 = cyc + 1;
        wr(8'h00, 32'h7, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            k = cyc - e0;
            rd(8'h0C, 32'(3 - (k % 4)), "t2_count");
        end
        k = cyc - e0;
        check_val("t2_irq", {31'h0, irq}, 32'(k >= 4));
        rd(8'h10, 32'h1, "t2_status");

        // One-shot: ticks land at +5, +10, +15 edges after the enable.
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h10, 32'h1, 4'h1);
        wr(8'h04, 32'h4, 4'hF);
        wr(8'h0C, 32'h2, 4'hF);
        e0 = cyc + 1;
        wr(8'h00, 32'h5, 4'hF);
        while (cyc - e0 < 20) begin
            @(negedge clk);
            check_val("t3_irq", {31'h0, irq}, 32'(cyc - e0 >= 15));
        end
        rd(8'h00, 32'h4, "t3_ctrl");
        rd(8'h0C, 32'h0, "t3_count");
        rd(8'h10, 32'h1, "t3_status");

        // Byte lanes and unmapped offsets.
        wr(8'h08, 32'h0, 4'hF);
        wr(8'h08, 32'hAABB_CCDD, 4'b0010);
        rd(8'h08, 32'h0000_CC00, "t4_load_lane");
        bus(8'h08, 32'h1234_5678, 4'hF, "t4_prewrite", 32'h0000_CC00, 1'b1);
        rd(8'h08, 32'h1234_5678, "t4_load_full");
        bus(8'h40, 32'h1, 4'hF, "t4_unmapped_wr", 32'h0, 1'b1);
        rd(8'h40, 32'h0, "t4_unmapped_rd");

        // W1C colliding with an expiry tick: ticks at +10, +20, +30 edges.
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h10, 32'h1, 4'h1);
        wr(8'h04, 32'h9, 4'hF);
        wr(8'h08, 32'h0, 4'hF);
        wr(8'h0C, 32'h0, 4'hF);
        e0 = cyc + 1;
        wr(8'h00, 32'h7, 4'hF);
        while (cyc < e0 + 11) @(negedge clk);
        bus(8'h10, 32'h1, 4'h1, "t5_w1c_a", 32'h1, 1'b1);
        check_val("t5_irq_cleared", {31'h0, irq}, 32'h0);
        while (cyc < e0 + 19) @(negedge clk);
        bus(8'h10, 32'h1, 4'h1, "t5_w1c_collide", 32'h0, 1'b1);
        check_val("t5_irq_collide", {31'h0, irq}, 32'h1);
        rd(8'h10, 32'h1, "t5_status_kept");
        bus(8'h10, 32'h1, 4'h1, "t5_w1c_b", 32'h1, 1'b1);
        check_val("t5_irq_dropped", {31'h0, irq}, 32'h0);
        rd(8'h10, 32'h0, "t5_status_clr");
        wr(8'h00, 32'h0, 4'hF);

        // Reset arriving in the accept cycle drops the response.
        wr(8'h08, 32'h5, 4'hF);
        wr(8'h04, 32'h3, 4'hF);
        wr(8'h00, 32'h2, 4'hF);
        iomem_addr  = BASE + 32'h8;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        check_val("t6_no_ready", {31'h0, iomem_ready}, 32'h0);
        iomem_valid = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        check_val("t6_no_ready_late", {31'h0, iomem_ready}, 32'h0);
        rd(8'h00, 32'h0, "t6_ctrl");
        rd(8'h04, 32'h0, "t6_prescale");
        rd(8'h08, 32'h0, "t6_load");
        rd(8'h0C, 32'h0, "t6_count");
        rd(8'h10, 32'h0, "t6_status");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
